// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared types, limits and saturation helper for sum_accumulator
//
// Contents:
//   state_t     : frame FSM states (IDLE, ACCUM, HOLD)
//   COUNT_WIDTH : width of the per-frame sample counter
//   sat_max/min : clamp limits of a signed value of a given width
//   sat         : integer reference clamp, usable from RTL constants or a bench model
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int COUNT_WIDTH = 16;

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

  function automatic int sat(input int value, input int width);
    if (value > sat_max(width)) begin
      return sat_max(width);
    end else if (value < sat_min(width)) begin
      return sat_min(width);
    end
    return value;
  endfunction

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// rtl/sum_accumulator_sat_add.sv - combinational signed add with clamp to OUT_WIDTH
//
// Ports:
//   i_acc     : running accumulator, signed OUT_WIDTH (always already in range)
//   i_sample  : new sample, signed IN_WIDTH (IN_WIDTH <= OUT_WIDTH)
//   o_sum     : clamped sum, signed OUT_WIDTH
//   o_clamped : high when the true sum fell outside the OUT_WIDTH range
module sum_accumulator_sat_add
  import sum_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 5
) (
  input  logic signed [OUT_WIDTH-1:0] i_acc,
  input  logic signed [IN_WIDTH-1:0]  i_sample,
  output logic signed [OUT_WIDTH-1:0] o_sum,
  output logic                        o_clamped
);

  // One extra bit is enough: an in-range accumulator plus a sample no wider
  // than it cannot overflow OUT_WIDTH+1 bits.
  localparam logic signed [OUT_WIDTH:0] LIM_HI = (OUT_WIDTH + 1)'(sat_max(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH:0] LIM_LO = (OUT_WIDTH + 1)'(sat_min(OUT_WIDTH));

  logic signed [OUT_WIDTH:0] w_acc_ext;
  logic signed [OUT_WIDTH:0] w_smp_ext;
  logic signed [OUT_WIDTH:0] w_raw;

  assign w_acc_ext = {i_acc[OUT_WIDTH-1], i_acc};
  assign w_smp_ext = {{(OUT_WIDTH + 1 - IN_WIDTH){i_sample[IN_WIDTH-1]}}, i_sample};
  assign w_raw     = w_acc_ext + w_smp_ext;

  always_comb begin
    o_sum     = w_raw[OUT_WIDTH-1:0];
    o_clamped = 1'b0;
    if (w_raw > LIM_HI) begin
      o_sum     = LIM_HI[OUT_WIDTH-1:0];
      o_clamped = 1'b1;
    end else if (w_raw < LIM_LO) begin
      o_sum     = LIM_LO[OUT_WIDTH-1:0];
      o_clamped = 1'b1;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - saturating accumulation of COUNT signed samples per frame
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous frame abort, drops any pending result and same-cycle sample
//   in_data       : signed IN_WIDTH sample, in_valid/in_ready handshake
//   out_data      : signed OUT_WIDTH frame result, out_valid/out_ready handshake
//   out_overflow  : frame clamped at least once, valid with out_data
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 5,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_overflow
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_W = COUNT_WIDTH'(COUNT);

  state_t                       r_state;
  logic   [COUNT_WIDTH-1:0]     r_count;
  logic   signed [OUT_WIDTH-1:0] r_acc;
  logic                         r_ovf;
  logic   [OUT_WIDTH-1:0]       r_out_data;
  logic                         r_out_valid;
  logic                         r_out_overflow;

  state_t                       w_state_nxt;
  logic   [COUNT_WIDTH-1:0]     w_count_nxt;
  logic   signed [OUT_WIDTH-1:0] w_acc_nxt;
  logic                         w_ovf_nxt;
  logic   [OUT_WIDTH-1:0]       w_out_data_nxt;
  logic                         w_out_valid_nxt;
  logic                         w_out_overflow_nxt;

  logic                         w_in_ready;
  logic                         w_in_accept;
  logic                         w_out_accept;
  logic   [COUNT_WIDTH-1:0]     w_count_inc;
  logic   signed [OUT_WIDTH-1:0] w_in_ext;
  logic   signed [OUT_WIDTH-1:0] w_sum;
  logic                         w_clamped;

  // Ready is a pure function of state so the upstream adder never sees a
  // combinational path from its own valid back to ready.
  assign w_in_ready   = (r_state != HOLD);
  assign w_in_accept  = in_valid & w_in_ready;
  assign w_out_accept = r_out_valid & out_ready;
  assign w_count_inc  = r_count + 1'b1;
  assign w_in_ext     = {{(OUT_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  sum_accumulator_sat_add #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_add (
    .i_acc     (r_acc),
    .i_sample  (in_data),
    .o_sum     (w_sum),
    .o_clamped (w_clamped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_acc          <= '0;
      r_ovf          <= 1'b0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_out_overflow <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_acc          <= w_acc_nxt;
      r_ovf          <= w_ovf_nxt;
      r_out_data     <= w_out_data_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_out_overflow <= w_out_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_count_nxt        = r_count;
    w_acc_nxt          = r_acc;
    w_ovf_nxt          = r_ovf;
    w_out_data_nxt     = r_out_data;
    w_out_valid_nxt    = r_out_valid;
    w_out_overflow_nxt = r_out_overflow;

    if (clear) begin
      // Abort wins over any handshake in the same cycle.
      w_state_nxt        = IDLE;
      w_count_nxt        = '0;
      w_acc_nxt          = '0;
      w_ovf_nxt          = 1'b0;
      w_out_data_nxt     = '0;
      w_out_valid_nxt    = 1'b0;
      w_out_overflow_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_accept) begin
            // First sample of a frame is loaded, not added, so it never clamps.
            w_acc_nxt   = w_in_ext;
            w_count_nxt = COUNT_WIDTH'(1);
            w_ovf_nxt   = 1'b0;
            if (COUNT_W == COUNT_WIDTH'(1)) begin
              w_out_data_nxt     = w_in_ext;
              w_out_overflow_nxt = 1'b0;
              w_out_valid_nxt    = 1'b1;
              w_state_nxt        = HOLD;
            end else begin
              w_state_nxt = ACCUM;
            end
          end
        end

        ACCUM: begin
          if (w_in_accept) begin
            w_acc_nxt   = w_sum;
            w_count_nxt = w_count_inc;
            w_ovf_nxt   = r_ovf | w_clamped;
            if (w_count_inc == COUNT_W) begin
              w_out_data_nxt     = w_sum;
              w_out_overflow_nxt = r_ovf | w_clamped;
              w_out_valid_nxt    = 1'b1;
              w_state_nxt        = HOLD;
            end
          end
        end

        HOLD: begin
          if (w_out_accept) begin
            w_state_nxt        = IDLE;
            w_count_nxt        = '0;
            w_acc_nxt          = '0;
            w_ovf_nxt          = 1'b0;
            w_out_data_nxt     = '0;
            w_out_valid_nxt    = 1'b0;
            w_out_overflow_nxt = 1'b0;
          end
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_overflow = r_out_overflow;

endmodule
